bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 14 +
 rtl/bcd_seg_scan.sv | 141 ++++++++++++++
 tb/tb_bcd_seg_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the two-digit BCD seven-segment scanner.
package bcd_seg_pkg;

    // Scan states in cyclic order; the BLANK_T -> SHOW_U step is the frame boundary.
    typedef enum logic [1:0] {
        SHOW_U  = 2'd0,
        BLANK_U = 2'd1,
        SHOW_T  = 2'd2,
        BLANK_T = 2'd3
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digits 0..9; non-BCD nibbles render as a dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup covers every nibble value, including the dash codes.
    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed BCD display driver with blanking gaps and
// frame-synchronous value updates through a one-deep pending register.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    output logic [6:0] seg,
    output logic [1:0] an
);

    // Wide enough to hold REFRESH_DIV-1 at its largest legal value.
    localparam int CNT_W = 21;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dwell_last;
    logic             dwell_done;
    logic             boundary;
    logic             transfer;
    logic [7:0]       disp, disp_next;
    logic [7:0]       pend;
    logic             pend_full;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_next;
    logic [1:0]       an_next;

    assign bcd_ready = !pend_full;
    assign transfer  = bcd_valid && !pend_full;

    // Dwell length depends on whether the current slot lights a digit.
    always_comb begin
        dwell_last = CNT_W'(BLANK_CYC - 1);
        if (state == SHOW_U || state == SHOW_T)
            dwell_last = CNT_W'(REFRESH_DIV - 1);
        dwell_done = (cnt == dwell_last);
        boundary   = dwell_done && (state == BLANK_T);
    end

    // Displayed value only moves at the frame boundary; an empty pend lets
    // a same-edge transfer go straight to the display.
    always_comb begin
        disp_next = disp;
        if (boundary) begin
            if (pend_full)
                disp_next = pend;
            else if (transfer)
                disp_next = bcd_in;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= BLANK_T;
        else
            state <= state_next;
    end

    // Next state plus the outputs that state will show, so the registered
    // seg/an switch on the same edge as the state.
    always_comb begin
        state_next = state;
        an_next    = 2'b11;
        seg_next   = SEG_BLANK;
        nib        = disp_next[3:0];
        if (dwell_done) begin
            case (state)
                SHOW_U:  state_next = BLANK_U;
                BLANK_U: state_next = SHOW_T;
                SHOW_T:  state_next = BLANK_T;
                default: state_next = SHOW_U;
            endcase
        end
        case (state_next)
            SHOW_U: begin
                an_next  = 2'b10;
                seg_next = dec_seg;
            end
            SHOW_T: begin
                nib = disp_next[7:4];
                if (disp_next[7:4] != 4'd0) begin
                    an_next  = 2'b01;
                    seg_next = dec_seg;
                end
            end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Shared dwell counter, restarted on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (dwell_done)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Holding registers: reset drops any pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp      <= 8'h00;
            pend      <= 8'h00;
            pend_full <= 1'b0;
        end else begin
            disp <= disp_next;
            if (boundary) begin
                pend_full <= 1'b0;
            end else if (transfer) begin
                pend      <= bcd_in;
                pend_full <= 1'b1;
            end
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 2'b11;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with REFRESH_DIV=4, BLANK_CYC=2 (12-cycle frame).
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bcd_in = 8'h00;
    logic       bcd_valid = 1'b0;
    logic       bcd_ready;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // rising edges since reset release

    bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // One clock edge; sample point is 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Frame phase after edge cyc: 0-3 SHOW_U, 4-5 BLANK_U, 6-9 SHOW_T, 10-11 BLANK_T.
    function automatic int phase();
        return (cyc >= 2) ? (cyc - 2) % 12 : -1;
    endfunction

    task automatic go_to(input int k);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = (phase() == k);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL go_to: phase %0d not reached, at %0d", k, phase());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (an !== 2'b11)     begin errors++; $display("FAIL rst_an: got %b want 11", an); end
        checks++; if (seg !== 7'h7F)    begin errors++; $display("FAIL rst_seg: got %h want 7F", seg); end
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bcd_ready); end
        rst = 1'b0;
        cyc = 0;
        step();
        checks++; if (an !== 2'b11) begin errors++; $display("FAIL rel_blank: got %b want 11", an); end
        for (int i = 0; i < 13; i++) begin
            logic [1:0] ea;
            logic [6:0] es;
            step();
            ea = (phase() < 4) ? 2'b10 : 2'b11;
            es = (phase() < 4) ? 7'h40 : 7'h7F;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL idle_frame ph%0d: got an=%b seg=%h want an=%b seg=%h", phase(), an, seg, ea, es);
            end
        end
    endtask

    task automatic test_transfer();
        go_to(7);
        bcd_in = 8'h42; bcd_valid = 1'b1;
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL xfer_ready_pre: got %b want 1", bcd_ready); end
        step();
        bcd_valid = 1'b0;
        checks++; if (bcd_ready !== 1'b0) begin errors++; $display("FAIL xfer_ready_busy: got %b want 0", bcd_ready); end
        checks++; if (an !== 2'b11) begin errors++; $display("FAIL xfer_no_early: got an=%b want 11", an); end
        go_to(0);
        checks++; if (an !== 2'b10 || seg !== 7'h24) begin errors++; $display("FAIL xfer_units: got an=%b seg=%h want 10/24", an, seg); end
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL xfer_ready_back: got %b want 1", bcd_ready); end
        go_to(6);
        checks++; if (an !== 2'b01 || seg !== 7'h19) begin errors++; $display("FAIL xfer_tens: got an=%b seg=%h want 01/19", an, seg); end
    endtask

    task automatic test_bypass();
        go_to(11);
        bcd_in = 8'h55; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        checks++; if (an !== 2'b10 || seg !== 7'h12) begin errors++; $display("FAIL bypass_units: got an=%b seg=%h want 10/12", an, seg); end
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b want 1", bcd_ready); end
        go_to(6);
        checks++; if (an !== 2'b01 || seg !== 7'h12) begin errors++; $display("FAIL bypass_tens: got an=%b seg=%h want 01/12", an, seg); end
    endtask

    task automatic test_back_to_back();
        go_to(1);
        bcd_in = 8'h3A; bcd_valid = 1'b1;
        step();
        bcd_in = 8'h99;
        checks++; if (bcd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", bcd_ready); end
        go_to(0);
        checks++; if (an !== 2'b10 || seg !== 7'h3F) begin errors++; $display("FAIL bp_units_dash: got an=%b seg=%h want 10/3F", an, seg); end
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_free: got %b want 1", bcd_ready); end
        step();
        bcd_valid = 1'b0;
        checks++; if (bcd_ready !== 1'b0) begin errors++; $display("FAIL bp_accept99: got ready=%b want 0", bcd_ready); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL bp_no_mix: got seg=%h want 3F", seg); end
        go_to(6);
        checks++; if (an !== 2'b01 || seg !== 7'h30) begin errors++; $display("FAIL bp_tens3: got an=%b seg=%h want 01/30", an, seg); end
        go_to(0);
        checks++; if (an !== 2'b10 || seg !== 7'h10) begin errors++; $display("FAIL bp_units9: got an=%b seg=%h want 10/10", an, seg); end
        go_to(6);
        checks++; if (an !== 2'b01 || seg !== 7'h10) begin errors++; $display("FAIL bp_tens9: got an=%b seg=%h want 01/10", an, seg); end
    endtask

    task automatic test_async_reset();
        go_to(1);
        bcd_in = 8'h77; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        checks++; if (bcd_ready !== 1'b0) begin errors++; $display("FAIL ar_pend_full: got ready=%b want 0", bcd_ready); end
        go_to(7);
        checks++; if (an !== 2'b01 || seg !== 7'h10) begin errors++; $display("FAIL ar_pre_tens: got an=%b seg=%h want 01/10", an, seg); end
        #2 rst = 1'b1;
        #1;
        checks++; if (an !== 2'b11 || seg !== 7'h7F) begin errors++; $display("FAIL ar_immediate: got an=%b seg=%h want 11/7F", an, seg); end
        checks++; if (bcd_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", bcd_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        step();
        checks++; if (an !== 2'b11) begin errors++; $display("FAIL ar_rel_blank: got an=%b want 11", an); end
        step();
        checks++; if (an !== 2'b10 || seg !== 7'h40) begin errors++; $display("FAIL ar_units0: got an=%b seg=%h want 10/40", an, seg); end
        go_to(6);
        checks++; if (an !== 2'b11 || seg !== 7'h7F) begin errors++; $display("FAIL ar_tens_blank: got an=%b seg=%h want 11/7F", an, seg); end
        go_to(0);
        checks++; if (an !== 2'b10 || seg !== 7'h40) begin errors++; $display("FAIL ar_pend_dropped: got an=%b seg=%h want 10/40", an, seg); end
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_bypass();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
